// File: rtl/witf_scoreboard.sv
// witf_scoreboard: write-in-flight table, an in-order FIFO of destination
// registers dispatched by IDU and not yet written back by WBU.
//
// Ports:
//   clk, rst           core clock (rising edge), async active-low reset
//   disp_en, rd        IDU push of a destination register
//   rs1, rs2           IDU source indices for the RAW check
//   isRAW              a valid in-flight entry matches rs1/rs2 (comb)
//   witf_full          count == DEPTH, registered state only
//   wb_en, wb_rd       WBU retire of the head entry
//   witf_empty         count == 0
//   witf_err           sticky overflow/underflow/mismatch flag
//
// Option macro WITF_WB_BYPASS_EN: when defined, the head entry is left out
// of the RAW compare in a cycle where it is being retired.
module witf_scoreboard #(
   parameter int DEPTH = 4,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          disp_en,
   input  logic [AW-1:0] rd,
   input  logic [AW-1:0] rs1,
   input  logic [AW-1:0] rs2,
   output logic          isRAW,
   output logic          witf_full,
   input  logic          wb_en,
   input  logic [AW-1:0] wb_rd,
   output logic          witf_empty,
   output logic          witf_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0]    entry [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             err_q;

   logic             push;
   logic             pop;
   logic             err_set;
   logic [DEPTH-1:0] hit;

   assign witf_full  = (count == FULL_CNT);
   assign witf_empty = (count == '0);
   assign witf_err   = err_q;

   // full does not look ahead to a same-cycle pop
   assign push = disp_en & ~witf_full;
   assign pop  = wb_en & ~witf_empty;

   assign err_set = (disp_en & witf_full)
                  | (wb_en & witf_empty)
                  | (pop & (wb_rd != entry[rd_ptr]));

   always_comb begin
      hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hit[i] = valid[i]
                & (((rs1 != '0) & (entry[i] == rs1))
                |  ((rs2 != '0) & (entry[i] == rs2)));
`ifdef WITF_WB_BYPASS_EN
         // regfile write-through covers the retiring head
         if (pop && (rd_ptr == PW'(i)))
            hit[i] = 1'b0;
`endif
      end
   end

   assign isRAW = |hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         err_q  <= 1'b0;
      end else begin
         if (pop) begin
            valid[rd_ptr] <= 1'b0;
            rd_ptr        <= rd_ptr + 1'b1;
         end
         if (push) begin
            valid[wr_ptr] <= 1'b1;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
         if (err_set)
            err_q <= 1'b1;
      end
   end

   // entry payload needs no reset; valid qualifies it
   always_ff @(posedge clk) begin
      if (push)
         entry[wr_ptr] <= rd;
   end

endmodule

// File: tb/tb_witf_scoreboard.sv
// tb_witf_scoreboard: directed and randomized checks of witf_scoreboard
// against a queue-based reference model of the in-flight table.
module tb_witf_scoreboard;

   localparam int DEPTH = 4;
   localparam int AW    = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          disp_en = 1'b0;
   logic [AW-1:0] rd = '0;
   logic [AW-1:0] rs1 = '0;
   logic [AW-1:0] rs2 = '0;
   logic          wb_en = 1'b0;
   logic [AW-1:0] wb_rd = '0;
   logic          isRAW;
   logic          witf_full;
   logic          witf_empty;
   logic          witf_err;

   int checks = 0;
   int errors = 0;

   int m_q[$];
   bit m_err;

   always #5 clk = ~clk;

   witf_scoreboard #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .disp_en    (disp_en),
      .rd         (rd),
      .rs1        (rs1),
      .rs2        (rs2),
      .isRAW      (isRAW),
      .witf_full  (witf_full),
      .wb_en      (wb_en),
      .wb_rd      (wb_rd),
      .witf_empty (witf_empty),
      .witf_err   (witf_err)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_raw(int a, int b, bit w);
      bit r = 0;
      for (int k = 0; k < m_q.size(); k++) begin
`ifdef WITF_WB_BYPASS_EN
         if (k == 0 && w) continue;
`endif
         if ((a != 0 && m_q[k] == a) || (b != 0 && m_q[k] == b))
            r = 1;
      end
      return r;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".raw"}, int'(isRAW), int'(m_raw(rs1, rs2, wb_en)));
      chk({tag, ".full"}, int'(witf_full), int'(m_q.size() == DEPTH));
      chk({tag, ".empty"}, int'(witf_empty), int'(m_q.size() == 0));
      chk({tag, ".err"}, int'(witf_err), int'(m_err));
   endtask

   // drive one cycle, check pre-edge outputs, then advance the model
   task automatic step(input string tag, input bit d, input int r,
                       input int a, input int b, input bit w, input int wr);
      bit full;
      bit empty;
      @(negedge clk);
      disp_en = d;
      rd      = AW'(r);
      rs1     = AW'(a);
      rs2     = AW'(b);
      wb_en   = w;
      wb_rd   = AW'(wr);
      #1;
      check_all(tag);
      @(posedge clk);
      full  = (m_q.size() == DEPTH);
      empty = (m_q.size() == 0);
      if (d && full) m_err = 1;
      if (w && empty) m_err = 1;
      if (w && !empty) begin
         if (m_q[0] != wr) m_err = 1;
         void'(m_q.pop_front());
      end
      if (d && !full) m_q.push_back(r);
   endtask

   task automatic do_reset();
      @(negedge clk);
      disp_en = 0;
      wb_en   = 0;
      rs1     = '0;
      rs2     = '0;
      rst     = 0;
      m_q.delete();
      m_err = 0;
      #1;
      check_all("rst");
      @(negedge clk);
      rst = 1;
   endtask

   initial begin
      int a;
      int b;
      int wr;
      bit w;
      do_reset();
      step("idle", 0, 0, 0, 0, 0, 0);

      // single push, RAW hits and misses, retire
      step("p5", 1, 5, 0, 0, 0, 0);
      step("raw5", 0, 0, 5, 0, 0, 0);
      step("raw0", 0, 0, 0, 0, 0, 0);
      step("raw6", 0, 0, 6, 0, 0, 0);
      step("wb5", 0, 0, 0, 0, 1, 5);
      step("aft5", 0, 0, 5, 0, 0, 0);

      // fill, then overflow
      for (int i = 1; i <= 4; i++)
         step("fill", 1, i, 0, 0, 0, 0);
      step("ovf", 1, 7, 0, 0, 0, 0);
      step("no7", 0, 0, 7, 4, 0, 0);

      // full: pop+push same cycle, push refused
      step("pp1", 1, 9, 0, 0, 1, 1);
      step("pp2", 1, 9, 9, 0, 1, 2);
      step("pop3", 0, 0, 0, 9, 1, 3);
      step("pop4", 0, 0, 0, 0, 1, 4);
      step("pop9", 0, 0, 9, 0, 1, 9);
      step("drain", 0, 0, 9, 0, 0, 0);

      // underflow
      do_reset();
      step("unf", 0, 0, 0, 0, 1, 3);
      step("unf2", 0, 0, 0, 0, 0, 0);

      // mismatch still pops
      do_reset();
      step("p8", 1, 8, 0, 0, 0, 0);
      step("mis", 0, 0, 8, 0, 1, 9);
      step("mis2", 0, 0, 8, 0, 0, 0);

      // retire-cycle bypass behaviour
      do_reset();
      step("p3", 1, 3, 0, 0, 0, 0);
      step("byp", 0, 0, 0, 3, 1, 3);
      step("byp2", 0, 0, 0, 3, 0, 0);

      // randomized batches
      for (int n = 0; n < 25; n++) begin
         do_reset();
         for (int c = 0; c < 40; c++) begin
            a = $urandom_range(0, 7);
            b = $urandom_range(0, 7);
            w = ($urandom_range(0, 2) == 0);
            if (m_q.size() > 0 && $urandom_range(0, 19) != 0)
               wr = m_q[0];
            else
               wr = $urandom_range(0, 7);
            step("rnd", ($urandom_range(0, 1) == 1),
                 $urandom_range(1, 7), a, b, w, wr);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
